// File: rtl/hwpe_tcdm_resp_pkg.sv
// Shared defaults and types for the HWPE TCDM bank responder.
package hwpe_tcdm_resp_pkg;

   localparam int unsigned DEF_MP        = 4;
   localparam int unsigned DEF_DW        = 32;
   localparam int unsigned DEF_AW        = 32;
   localparam int unsigned DEF_N_WORDS   = 1024;
   localparam logic [31:0] DEF_BASE_ADDR = 32'h1000_0000;
   localparam logic [31:0] DEF_OOB_RDATA = 32'hDEAD_BEEF;

   typedef logic [DEF_DW-1:0] tcdm_word_t;

   // TCDM encodes the operation on wen: 1 = read, 0 = write
   typedef enum logic {
      TCDM_WRITE = 1'b0,
      TCDM_READ  = 1'b1
   } tcdm_op_e;

endpackage

// File: rtl/hwpe_tcdm_bank_responder_if.sv
// Flattened multi-port TCDM request/response bundle.
interface hwpe_tcdm_bank_responder_if
   import hwpe_tcdm_resp_pkg::*;
#(
   parameter int unsigned MP = DEF_MP,
   parameter int unsigned DW = DEF_DW,
   parameter int unsigned AW = DEF_AW
);
   logic [MP-1:0]                 req;
   logic [MP-1:0][AW-1:0]         add;
   logic [MP-1:0]                 wen;
   logic [MP-1:0][DW/8-1:0]       be;
   logic [MP-1:0][DW-1:0]         data;
   logic [MP-1:0]                 gnt;
   logic [MP-1:0][DW-1:0]         r_data;
   logic [MP-1:0]                 r_valid;

   modport master (
      output req, add, wen, be, data,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, add, wen, be, data,
      output gnt, r_data, r_valid
   );
endinterface

// File: rtl/hwpe_tcdm_rr_arb.sv
// MP-way round-robin arbiter: one grant per cycle, search starts at ptr.
module hwpe_tcdm_rr_arb
   import hwpe_tcdm_resp_pkg::*;
#(
   parameter int unsigned MP = DEF_MP,
   localparam int unsigned IW = (MP > 1) ? $clog2(MP) : 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [MP-1:0] req,
   input  logic          en,
   output logic [MP-1:0] gnt,
   output logic [IW-1:0] idx,
   output logic          valid
);

   logic [IW-1:0] ptr;
   logic [IW:0]   sum;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      sum   = '0;
      for (int unsigned i = 0; i < MP; i++) begin
         sum = {1'b0, ptr} + (IW+1)'(i);
         if (sum >= (IW+1)'(MP)) sum = sum - (IW+1)'(MP);
         if (!valid && en && req[sum[IW-1:0]]) begin
            valid              = 1'b1;
            idx                = sum[IW-1:0];
            gnt[sum[IW-1:0]]   = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         ptr <= '0;
      end else if (valid) begin
         ptr <= (idx == IW'(MP-1)) ? '0 : idx + 1'b1;
      end
   end

endmodule

// File: rtl/hwpe_tcdm_bank_responder.sv
// Single-bank TCDM responder: round-robin grant, one-cycle response latency.
module hwpe_tcdm_bank_responder
   import hwpe_tcdm_resp_pkg::*;
#(
   parameter int unsigned    MP        = DEF_MP,
   parameter int unsigned    DW        = DEF_DW,
   parameter int unsigned    AW        = DEF_AW,
   parameter int unsigned    N_WORDS   = DEF_N_WORDS,
   parameter logic [AW-1:0]  BASE_ADDR = AW'(DEF_BASE_ADDR),
   parameter logic [DW-1:0]  OOB_RDATA = DW'(DEF_OOB_RDATA)
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   hwpe_tcdm_bank_responder_if.slave  tcdm,
   input  logic                       stall_i,
   output logic                       oob_err_o
);

   localparam int unsigned IW   = (MP > 1) ? $clog2(MP) : 1;
   localparam int unsigned WIDX = $clog2(N_WORDS);

   logic [MP-1:0]   gnt;
   logic [IW-1:0]   win;
   logic            valid;

   logic [AW-1:0]   add_sel;
   logic [AW-1:0]   off;
   logic [DW/8-1:0] be_sel;
   logic [DW-1:0]   data_sel;
   tcdm_op_e        op;
   logic            in_range;
   logic [WIDX-1:0] widx;
   logic            unused_bits;

   logic [DW-1:0]         mem [N_WORDS];
   logic [MP-1:0][DW-1:0] r_data_q;
   logic [MP-1:0]         r_valid_q;

   // Reset gates the arbiter so no grant (and no write) happens in a reset cycle
   hwpe_tcdm_rr_arb #(.MP(MP)) i_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req    (tcdm.req),
      .en     (!stall_i && rst_ni),
      .gnt    (gnt),
      .idx    (win),
      .valid  (valid)
   );

   assign add_sel  = tcdm.add[win];
   assign be_sel   = tcdm.be[win];
   assign data_sel = tcdm.data[win];
   assign op       = tcdm_op_e'(tcdm.wen[win]);

   assign off      = add_sel - BASE_ADDR;
   assign in_range = (add_sel >= BASE_ADDR) && (off < AW'(N_WORDS*4));
   assign widx     = off[WIDX+1:2];
   assign unused_bits = ^{off[AW-1:WIDX+2], off[1:0]};

   always_ff @(posedge clk_i) begin
      if (valid && op == TCDM_WRITE && in_range) begin
         for (int unsigned b = 0; b < DW/8; b++) begin
            if (be_sel[b]) mem[widx][b*8 +: 8] <= data_sel[b*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_valid_q <= '0;
         r_data_q  <= '0;
         oob_err_o <= 1'b0;
      end else begin
         r_valid_q <= gnt;
         if (valid) begin
            if (op == TCDM_READ) r_data_q[win] <= in_range ? mem[widx] : OOB_RDATA;
            else                 r_data_q[win] <= '0;
            if (!in_range) oob_err_o <= 1'b1;
         end
      end
   end

   assign tcdm.gnt     = gnt;
   assign tcdm.r_data  = r_data_q;
   assign tcdm.r_valid = r_valid_q;

endmodule
